// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle for hazard_fwd_unit.
// The master drives ID fields, control and datapath values.
// The slave (the hazard unit) returns the stall, the forwarding selects and the forwarded operands.
interface hazard_fwd_unit_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic                        hold;
  logic                        flush;
  logic                        id_valid;
  logic [NUM_SRC*REG_AW-1:0]   id_src;
  logic [NUM_SRC-1:0]          id_src_used;
  logic                        id_wr_en;
  logic [REG_AW-1:0]           id_rd;
  logic                        id_is_load;
  logic [NUM_SRC*DATA_W-1:0]   ex_opnd_in;
  logic [DATA_W-1:0]           exmem_data;
  logic [DATA_W-1:0]           memwb_data;
  logic                        stall;
  logic [NUM_SRC*2-1:0]        fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   ex_opnd_out;
  logic [31:0]                 stall_count;
  logic [31:0]                 fwd_count;

  modport master (
    output hold, flush, id_valid, id_src, id_src_used, id_wr_en, id_rd, id_is_load,
           ex_opnd_in, exmem_data, memwb_data,
    input  stall, fwd_sel, ex_opnd_out, stall_count, fwd_count
  );

  modport slave (
    input  hold, flush, id_valid, id_src, id_src_used, id_wr_en, id_rd, id_is_load,
           ex_opnd_in, exmem_data, memwb_data,
    output stall, fwd_sel, ex_opnd_out, stall_count, fwd_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall detection and EX operand forwarding.
// The unit tracks in-flight destination tags for the EX, MEM and WB stages.
// The optional performance counters are enabled by defining HAZ_PERF_EN.
module hazard_fwd_unit #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_fwd_unit_if.slave bus
);

  localparam int SRC_W = NUM_SRC * REG_AW;

  // EX tag: the instruction whose operands are being forwarded this cycle
  logic                 r_ex_valid;
  logic                 r_ex_wr_en;
  logic                 r_ex_is_load;
  logic [REG_AW-1:0]    r_ex_rd;
  logic [SRC_W-1:0]     r_ex_src;
  logic [NUM_SRC-1:0]   r_ex_src_used;

  // MEM tag
  logic                 r_mem_valid;
  logic                 r_mem_wr_en;
  logic                 r_mem_is_load;
  logic [REG_AW-1:0]    r_mem_rd;

  // WB tag. Its value is always final (ALU or load data), so the load flag is
  // never consulted here and is not stored.
  logic                 r_wb_valid;
  logic                 r_wb_wr_en;
  logic [REG_AW-1:0]    r_wb_rd;

  logic [NUM_SRC-1:0]          w_stall_hit;
  logic                        w_stall;
  logic [NUM_SRC*2-1:0]        w_fwd_sel;
  logic [NUM_SRC*DATA_W-1:0]   w_opnd;
  logic                        w_ex_load;

  assign w_ex_load = bus.id_valid & ~bus.flush & ~w_stall;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] w_id_src;
      logic [REG_AW-1:0] w_ex_src;
      logic              w_ex_load_hit;
      logic              w_mem_load_hit;
      logic              w_mem_wr;
      logic              w_wb_wr;
      logic [1:0]        w_sel;
      logic [DATA_W-1:0] w_data;

      // Load-use detection for the instruction sitting in ID
      assign w_id_src       = bus.id_src[gi*REG_AW +: REG_AW];
      assign w_ex_load_hit  = r_ex_valid & r_ex_wr_en & r_ex_is_load & (r_ex_rd == w_id_src);
      assign w_mem_load_hit = (LOAD_LAT == 2) & r_mem_valid & r_mem_wr_en & r_mem_is_load
                              & (r_mem_rd == w_id_src);
      assign w_stall_hit[gi] = bus.id_src_used[gi] & (w_id_src != '0)
                               & (w_ex_load_hit | w_mem_load_hit);

      // Producer match for the instruction sitting in EX; register 0 never matches
      assign w_ex_src = r_ex_src[gi*REG_AW +: REG_AW];
      assign w_mem_wr = r_mem_valid & r_mem_wr_en & (r_mem_rd == w_ex_src) & (w_ex_src != '0);
      assign w_wb_wr  = r_wb_valid & r_wb_wr_en & (r_wb_rd == w_ex_src) & (w_ex_src != '0);

      // Operand select: the youngest producer wins. A load still in MEM has no
      // data yet, so it falls back to the register file (the stall prevents this).
      always_comb begin
        w_sel  = 2'd0;
        w_data = bus.ex_opnd_in[gi*DATA_W +: DATA_W];
        if (r_ex_src_used[gi]) begin
          if (w_mem_wr) begin
            if (!r_mem_is_load) begin
              w_sel  = 2'd1;
              w_data = bus.exmem_data;
            end
          end else if (w_wb_wr) begin
            w_sel  = 2'd2;
            w_data = bus.memwb_data;
          end
        end
      end

      assign w_fwd_sel[gi*2 +: 2]       = w_sel;
      assign w_opnd[gi*DATA_W +: DATA_W] = w_data;
    end
  endgenerate

  assign w_stall         = bus.id_valid & ~bus.flush & (|w_stall_hit);
  assign bus.stall       = w_stall;
  assign bus.fwd_sel     = w_fwd_sel;
  assign bus.ex_opnd_out = w_opnd;

  // Tag pipeline: advance unless held; stalled or flushed ID becomes a bubble
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_wr_en    <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_src      <= '0;
      r_ex_src_used <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_is_load <= 1'b0;
      r_mem_rd      <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_wr_en    <= 1'b0;
      r_wb_rd       <= '0;
    end else if (!bus.hold) begin
      r_wb_valid    <= r_mem_valid;
      r_wb_wr_en    <= r_mem_wr_en;
      r_wb_rd       <= r_mem_rd;
      r_mem_valid   <= r_ex_valid;
      r_mem_wr_en   <= r_ex_wr_en;
      r_mem_is_load <= r_ex_is_load;
      r_mem_rd      <= r_ex_rd;
      r_ex_valid    <= w_ex_load;
      r_ex_wr_en    <= bus.id_wr_en;
      r_ex_is_load  <= bus.id_is_load;
      r_ex_rd       <= bus.id_rd;
      r_ex_src      <= bus.id_src;
      r_ex_src_used <= bus.id_src_used;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_fwd_count;

  // Performance counters: one count per unheld stall / forwarding cycle, wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else if (!bus.hold) begin
      if (w_stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (|w_fwd_sel) begin
        r_fwd_count <= r_fwd_count + 32'd1;
      end
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.fwd_count   = r_fwd_count;
`else
  assign bus.stall_count = '0;
  assign bus.fwd_count   = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit (default parameters, LOAD_LAT=1).
module tb_hazard_fwd_unit;

  localparam logic [63:0] OPND_IN = 64'hBBBB0002_AAAA0001;
`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  hazard_fwd_unit_if #(.DATA_W(32), .REG_AW(5), .NUM_SRC(2)) bus ();

  hazard_fwd_unit #(
    .DATA_W(32), .REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic drive_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic wr, input logic [4:0] rd,
                          input logic ld);
    bus.id_valid    = v;
    bus.id_src      = {s1, s0};
    bus.id_src_used = used;
    bus.id_wr_en    = wr;
    bus.id_rd       = rd;
    bus.id_is_load  = ld;
  endtask

  task automatic nop();
    drive_id(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.hold = 1'b0;
    bus.flush = 1'b0;
    bus.ex_opnd_in = OPND_IN;
    bus.exmem_data = '0;
    bus.memwb_data = '0;
    drive_id(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 1'b0);
    tick();
    #1;
    check("rst_stall", bus.stall, 1'b0);
    check("rst_sel", bus.fwd_sel, 4'h0);
    check("rst_opnd", bus.ex_opnd_out, OPND_IN);
    check("rst_stall_cnt", bus.stall_count, 32'd0);
    check("rst_fwd_cnt", bus.fwd_count, 32'd0);
    rst_n = 1'b1;

    // ADD r1=r2+r3 ; SUB r4=r1-r5 ; ADD r6=r1+r7
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0); #1;
    check("add_stall", bus.stall, 1'b0);
    tick();
    drive_id(1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 5'd4, 1'b0); #1;
    check("sub_id_stall", bus.stall, 1'b0);
    check("add_ex_sel", bus.fwd_sel, 4'h0);
    tick();
    drive_id(1'b1, 5'd1, 5'd7, 2'b11, 1'b1, 5'd6, 1'b0);
    bus.exmem_data = 32'd30;
    bus.ex_opnd_in = {32'd5, 32'hAAAA0001}; #1;
    check("sub_sel_mem", bus.fwd_sel, 4'h1);
    check("sub_opnd0", bus.ex_opnd_out[31:0], 32'd30);
    check("sub_result", bus.ex_opnd_out[31:0] - bus.ex_opnd_out[63:32], 32'd25);
    check("sub_stall", bus.stall, 1'b0);
    tick();
    nop();
    bus.exmem_data = 32'd25;
    bus.memwb_data = 32'd30;
    bus.ex_opnd_in = {32'd3, 32'hAAAA0001}; #1;
    check("add6_sel_wb", bus.fwd_sel, 4'h2);
    check("add6_result", bus.ex_opnd_out[31:0] + bus.ex_opnd_out[63:32], 32'd33);
    tick();
    bus.ex_opnd_in = OPND_IN;

    // ADD r1 ; nop ; SW r1,0(r8) -> store data forwarded from WB
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0); #1;
    check("bubble_sel", bus.fwd_sel, 4'h0);
    tick();
    nop(); tick();
    drive_id(1'b1, 5'd8, 5'd1, 2'b11, 1'b0, 5'd0, 1'b0); tick();
    nop();
    bus.memwb_data = 32'd30;
    bus.exmem_data = 32'd0; #1;
    check("sw_sel", bus.fwd_sel, 4'h8);
    check("sw_data", bus.ex_opnd_out[63:32], 32'd30);
    check("sw_base", bus.ex_opnd_out[31:0], 32'hAAAA0001);
    tick();

    // LW r9 ; ADD r10=r9+r2 -> exactly one stall, then WB forward
    drive_id(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd9, 1'b1); tick();
    drive_id(1'b1, 5'd9, 5'd2, 2'b11, 1'b1, 5'd10, 1'b0); #1;
    check("lu_stall1", bus.stall, 1'b1);
    tick(); #1;
    check("lu_stall2", bus.stall, 1'b0);
    tick();
    nop();
    bus.memwb_data = 32'd77; #1;
    check("lu_sel", bus.fwd_sel, 4'h2);
    check("lu_opnd", bus.ex_opnd_out[31:0], 32'd77);
    tick();

    // Two producers of r1: youngest (EX/MEM, value 2) wins
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0); tick();
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0); tick();
    drive_id(1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 5'd4, 1'b0); tick();
    nop();
    bus.exmem_data = 32'd2;
    bus.memwb_data = 32'd1; #1;
    check("young_sel", bus.fwd_sel, 4'h1);
    check("young_opnd", bus.ex_opnd_out[31:0], 32'd2);
    tick();

    // Register 0: ADD r0 ; read r0 ; LW r0 ; read r0
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd0, 1'b0); tick();
    drive_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd11, 1'b0); tick();
    drive_id(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd0, 1'b1); #1;
    check("r0_sel", bus.fwd_sel, 4'h0);
    tick();
    drive_id(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd11, 1'b0); #1;
    check("r0_stall", bus.stall, 1'b0);
    tick();

    // LW r9 ; dependent ADD r10 flushed -> no stall, bubble into EX
    drive_id(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd9, 1'b1); tick();
    drive_id(1'b1, 5'd9, 5'd2, 2'b11, 1'b1, 5'd10, 1'b0);
    bus.flush = 1'b1; #1;
    check("flush_stall", bus.stall, 1'b0);
    tick();
    bus.flush = 1'b0;
    drive_id(1'b1, 5'd10, 5'd0, 2'b01, 1'b1, 5'd12, 1'b0); tick();
    nop();
    bus.exmem_data = 32'd55; #1;
    check("flush_bubble", bus.fwd_sel, 4'h0);
    tick();

    // Load-use stall held for 3 cycles: state and counters frozen
    drive_id(1'b1, 5'd8, 5'd0, 2'b01, 1'b1, 5'd9, 1'b1); tick();
    drive_id(1'b1, 5'd9, 5'd2, 2'b11, 1'b1, 5'd10, 1'b0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_stall%0d", i), bus.stall, 1'b1);
      check($sformatf("hold_scnt%0d", i), bus.stall_count, pc(1));
      check($sformatf("hold_fcnt%0d", i), bus.fwd_count, pc(5));
      tick();
    end
    bus.hold = 1'b0; #1;
    check("unhold_stall", bus.stall, 1'b1);
    tick(); #1;
    check("unhold_stall2", bus.stall, 1'b0);
    check("scnt_after", bus.stall_count, pc(2));
    tick();
    nop();
    bus.memwb_data = 32'd88; #1;
    check("hold_lu_sel", bus.fwd_sel, 4'h2);
    check("hold_lu_opnd", bus.ex_opnd_out[31:0], 32'd88);
    tick();

    // Reset mid-stream after ADD r1: consumer must not see a stale forward
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0); #1;
    check("fcnt_pre_rst", bus.fwd_count, pc(6));
    tick();
    rst_n = 1'b0;
    drive_id(1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 5'd4, 1'b0);
    tick();
    rst_n = 1'b1; #1;
    check("rst2_scnt", bus.stall_count, 32'd0);
    check("rst2_fcnt", bus.fwd_count, 32'd0);
    tick();
    drive_id(1'b1, 5'd2, 5'd3, 2'b11, 1'b1, 5'd1, 1'b0);
    bus.exmem_data = 32'd30;
    bus.memwb_data = 32'd30; #1;
    check("rst2_sel", bus.fwd_sel, 4'h0);
    tick();
    drive_id(1'b1, 5'd1, 5'd5, 2'b11, 1'b1, 5'd4, 1'b0); tick();
    nop(); #1;
    check("post_rst_sel", bus.fwd_sel, 4'h1);
    tick(); #1;
    check("post_rst_fcnt", bus.fwd_count, pc(1));
    check("post_rst_scnt", bus.stall_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
